// File: rtl/id_scoreboard_fwd_pkg.sv
// Shared pipeline definitions for the ID-stage scoreboard and forwarding unit.
//   - default geometry (register file, data path, forwarding depth)
//   - canonical producer latencies
//   - forwarding slice width and stage indices; stage slice layout is {we, waddr, wdata}
package id_scoreboard_fwd_pkg;

  localparam int unsigned DEF_NREG    = 32;
  localparam int unsigned DEF_AW      = 5;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_NSTAGE  = 3;
  localparam int unsigned DEF_LW      = 3;
  localparam int unsigned DEF_MAX_LAT = 7;

  // Cycles until a producer's result is forwardable back to ID.
  localparam int unsigned LAT_ALU    = 1;
  localparam int unsigned LAT_LOAD   = 2;
  localparam int unsigned LAT_MULDIV = DEF_MAX_LAT;

  localparam int unsigned FWD_SLICE_WD = 1 + DEF_AW + DEF_DW;

  // Index 0 is the youngest stage; higher indices are older.
  localparam int unsigned FWD_EX  = 0;
  localparam int unsigned FWD_MEM = 1;
  localparam int unsigned FWD_WB  = 2;

endpackage

// File: rtl/id_scoreboard_fwd_mux.sv
// Priority forward of one source operand (fwd_mux).
// Ports:
//   src      - source register address
//   rf_rdata - register-file value, used when no stage matches
//   fwd_bus  - NSTAGE slices of {we, waddr, wdata}, slice i at bits [i*(1+AW+DW) +: 1+AW+DW]
//   data     - resolved operand; register 0 always reads as zero
module id_scoreboard_fwd_mux
  import id_scoreboard_fwd_pkg::*;
#(
  parameter int unsigned NSTAGE = DEF_NSTAGE,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned DW     = DEF_DW
) (
  input  logic [AW-1:0]              src,
  input  logic [DW-1:0]              rf_rdata,
  input  logic [NSTAGE*(1+AW+DW)-1:0] fwd_bus,
  output logic [DW-1:0]              data
);

  localparam int unsigned SW = 1 + AW + DW;

  always_comb begin
    data = rf_rdata;
    // Walk oldest to youngest so the youngest matching stage is applied last and wins.
    for (int i = int'(NSTAGE) - 1; i >= 0; i--) begin
      if (fwd_bus[i*SW + DW + AW] && (fwd_bus[i*SW + DW +: AW] == src)) begin
        data = fwd_bus[i*SW +: DW];
      end
    end
    if (src == '0) begin
      data = '0;
    end
  end

endmodule

// File: rtl/id_scoreboard_fwd.sv
// ID-stage hazard scoreboard and operand forwarding.
// A per-register down-counter records how many cycles remain until an in-flight producer's
// result can be forwarded back to ID; a reader of a busy register stalls. Operands are then
// resolved from the youngest matching write-back slice, falling back to the register file.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   freeze                - downstream stall; counters hold and nothing issues
//   flush                 - ID instruction is killed; no issue, counters still drain
//   id_valid, id_rs*, id_rt*, id_we, id_waddr, id_lat - decoded ID instruction
//   rf_rdata1, rf_rdata2  - register-file read data for rs / rt
//   fwd_bus               - NSTAGE slices of {we, waddr, wdata}, index 0 youngest
//   src1_data, src2_data  - resolved rs / rt operands
//   stall_req             - ID must hold this cycle
//   issue                 - instruction leaves ID this cycle
//   busy_mask             - bit r set while register r has a pending producer
module id_scoreboard_fwd
  import id_scoreboard_fwd_pkg::*;
#(
  parameter int unsigned NREG    = DEF_NREG,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned NSTAGE  = DEF_NSTAGE,
  parameter int unsigned LW      = DEF_LW,
  parameter int unsigned MAX_LAT = DEF_MAX_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic                        flush,
  input  logic                        id_valid,
  input  logic                        id_rs_used,
  input  logic [AW-1:0]               id_rs,
  input  logic                        id_rt_used,
  input  logic [AW-1:0]               id_rt,
  input  logic                        id_we,
  input  logic [AW-1:0]               id_waddr,
  input  logic [LW-1:0]               id_lat,
  input  logic [DW-1:0]               rf_rdata1,
  input  logic [DW-1:0]               rf_rdata2,
  input  logic [NSTAGE*(1+AW+DW)-1:0] fwd_bus,
  output logic [DW-1:0]               src1_data,
  output logic [DW-1:0]               src2_data,
  output logic                        stall_req,
  output logic                        issue,
  output logic [NREG-1:0]             busy_mask
);

  localparam logic [LW-1:0] MaxLat = LW'(MAX_LAT);
  localparam logic [LW-1:0] LatOne = LW'(1);

  logic [LW-1:0] cnt_q [NREG];
  logic [LW-1:0] cnt_d [NREG];
  logic [LW-1:0] eff_lat;
  logic          rs_busy, rt_busy, haz;

  // Hazard check uses pre-update counters, so a self-dependent instruction sees the old producer.
  assign rs_busy   = id_rs_used && (id_rs != '0) && (cnt_q[id_rs] != '0);
  assign rt_busy   = id_rt_used && (id_rt != '0) && (cnt_q[id_rt] != '0);
  assign haz       = rs_busy || rt_busy;
  assign stall_req = id_valid && haz && !flush;
  assign issue     = id_valid && !haz && !freeze && !flush;

  always_comb begin
    if (id_lat == '0) begin
      eff_lat = LatOne;
    end else if (id_lat > MaxLat) begin
      eff_lat = MaxLat;
    end else begin
      eff_lat = id_lat;
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      cnt_d[r] = cnt_q[r];
    end
    if (!freeze) begin
      for (int r = 0; r < int'(NREG); r++) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - LatOne;
        end
      end
      // A newer writer always wins, even with a shorter latency: forwarding picks the youngest.
      if (issue && id_we && (id_waddr != '0)) begin
        cnt_d[id_waddr] = eff_lat - LatOne;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NREG); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < int'(NREG); r++) begin
      busy_mask[r] = (cnt_q[r] != '0);
    end
  end

  id_scoreboard_fwd_mux #(
    .NSTAGE (NSTAGE),
    .AW     (AW),
    .DW     (DW)
  ) u_fwd_mux_rs (
    .src      (id_rs),
    .rf_rdata (rf_rdata1),
    .fwd_bus  (fwd_bus),
    .data     (src1_data)
  );

  id_scoreboard_fwd_mux #(
    .NSTAGE (NSTAGE),
    .AW     (AW),
    .DW     (DW)
  ) u_fwd_mux_rt (
    .src      (id_rt),
    .rf_rdata (rf_rdata2),
    .fwd_bus  (fwd_bus),
    .data     (src2_data)
  );

endmodule
